// File: rtl/norm_pkg.sv
// norm_pkg: shared types and constants for the bit normalizer.
//   norm_state_t : controller states (IDLE, SHIFT, DONE)
//   DIR_LEFT     : left-justify / count leading zeros. The ALU shift path uses the same encoding.
//   DIR_RIGHT    : right-justify / count trailing zeros
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/bit_normalizer_if.sv
// bit_normalizer_if: request/result bundle of the bit normalizer.
//   start, operand, direction : request from the master
//   busy, done                : job status from the slave
//   result, shiftAmount, zero : justified value, shift count and zero flag
//   state_dbg                 : controller state, for observation only
//
// Handshake: start is a level request. The slave samples start, operand and
// direction on a rising clock edge only while it is idle. Requests made while
// busy is high are dropped, and none are queued. done pulses for exactly one
// cycle per accepted request. result, shiftAmount and zero are valid in that
// cycle and hold their values until the next accepted request completes.
interface bit_normalizer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
);
    import norm_pkg::*;

    logic             start;
    logic [WIDTH-1:0] operand;
    logic             direction;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] shiftAmount;
    logic             zero;
    norm_state_t      state_dbg;

    modport master (
        output start, operand, direction,
        input  busy, done, result, shiftAmount, zero, state_dbg
    );

    modport slave (
        input  start, operand, direction,
        output busy, done, result, shiftAmount, zero, state_dbg
    );

endinterface

// File: rtl/bit_normalizer.sv
// bit_normalizer: multi-cycle normalizer. It shifts an operand one bit per
// cycle until the target bit is set. With direction=1 the target is the MSB
// (leading-zero count). With direction=0 the target is the LSB (trailing-zero
// count). It returns the justified value and the number of shifts applied.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; an in-flight job is discarded
//   bus   : bit_normalizer_if slave modport (request, status, result)
module bit_normalizer
    import norm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    bit_normalizer_if.slave bus
);

    norm_state_t      state, state_nxt;
    logic [WIDTH-1:0] work, work_nxt;
    logic             dir, dir_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             out_load;
    logic             target_bit;

    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] shamt_q;
    logic             zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            dir   <= DIR_RIGHT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            work  <= work_nxt;
            dir   <= dir_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        work_nxt   = work;
        dir_nxt    = dir;
        cnt_nxt    = cnt;
        out_load   = 1'b0;
        target_bit = (dir == DIR_LEFT) ? work[WIDTH-1] : work[0];
        case (state)
            IDLE: begin
                if (bus.start) begin
                    work_nxt  = bus.operand;
                    dir_nxt   = bus.direction;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // A zero operand never reaches the target bit, so it stops at once.
                // A nonzero operand reaches the target bit within WIDTH-1 shifts,
                // so cnt cannot wrap.
                if ((work == '0) || target_bit) begin
                    out_load  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    work_nxt = (dir == DIR_LEFT) ? {work[WIDTH-2:0], 1'b0}
                                                 : {1'b0, work[WIDTH-1:1]};
                    cnt_nxt  = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The result registers load on the edge into DONE. They are therefore valid
    // in the done cycle, and they hold until the next job completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            shamt_q  <= '0;
            zero_q   <= 1'b0;
        end else if (out_load) begin
            result_q <= work;
            shamt_q  <= cnt;
            zero_q   <= (work == '0);
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.result      = result_q;
    assign bus.shiftAmount = shamt_q;
    assign bus.zero        = zero_q;
    assign bus.state_dbg   = state;

endmodule
